// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_pkg
// Brief    : Shared constants for the serial packed-BCD adder.
// Revision : 1.0
// ============================================================================
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_MAX     = 9;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/bcd_digit_add.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_add
// Brief    : Combinational single-digit BCD adder with decimal correction.
// Revision : 1.0
// ============================================================================
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    output logic [3:0] digit,
    output logic       cout
);

    logic [4:0] w_t;

    assign w_t   = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
    assign cout  = (w_t > 5'(BCD_MAX));
    // t - 10 equals t + 6 modulo 16 for t in 10..19
    assign digit = cout ? (w_t[3:0] + 4'd6) : w_t[3:0];

endmodule
`default_nettype wire

// File: rtl/bcd_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bcd_serial_add_ctrl
// Brief    : Digit-serial packed-BCD adder sequencer, LSD first, one digit/clk.
// Revision : 1.0
// ============================================================================
module bcd_serial_add_ctrl
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [4*DIGITS-1:0]  a,
    input  logic [4*DIGITS-1:0]  b,
    output logic                 busy,
    output logic                 done,
    output logic [4*DIGITS-1:0]  sum,
    output logic                 carry_out,
    output logic                 error
);

    localparam int W     = DIGITS * BCD_DIGIT_W;
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DIGITS - 1);

    logic [1:0]       r_state;
    logic [W-1:0]     r_a_sh;
    logic [W-1:0]     r_b_sh;
    logic [W-1:0]     r_acc;
    logic [W-1:0]     r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_err;
    logic [CNT_W-1:0] r_idx;

    logic [DIGITS-1:0] w_bad;
    logic              w_any_bad;
    logic [3:0]        w_digit;
    logic              w_cout;
    logic [W-1:0]      w_acc_next;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_chk
            assign w_bad[gi] = (a[gi*BCD_DIGIT_W +: BCD_DIGIT_W] > 4'(BCD_MAX)) ||
                               (b[gi*BCD_DIGIT_W +: BCD_DIGIT_W] > 4'(BCD_MAX));
        end
    endgenerate

    assign w_any_bad = |w_bad;

    bcd_digit_add u_digit (
        .x     (r_a_sh[BCD_DIGIT_W-1:0]),
        .y     (r_b_sh[BCD_DIGIT_W-1:0]),
        .cin   (r_carry),
        .digit (w_digit),
        .cout  (w_cout)
    );

    // New digit enters at the top; after DIGITS shifts digit 0 sits at the bottom
    assign w_acc_next = (r_acc >> BCD_DIGIT_W) | (W'(w_digit) << (W - BCD_DIGIT_W));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_acc   <= '0;
                        r_carry <= 1'b0;
                        r_idx   <= '0;
                        if (w_any_bad) begin
                            r_sum   <= '0;
                            r_cout  <= 1'b0;
                            r_err   <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_ADD;
                        end
                    end
                end
                ST_ADD: begin
                    r_a_sh  <= r_a_sh >> BCD_DIGIT_W;
                    r_b_sh  <= r_b_sh >> BCD_DIGIT_W;
                    r_acc   <= w_acc_next;
                    r_carry <= w_cout;
                    r_idx   <= r_idx + 1'b1;
                    // Visible result only changes here, so it swaps atomically with done
                    if (r_idx == LAST_IDX) begin
                        r_sum   <= w_acc_next;
                        r_cout  <= w_cout;
                        r_err   <= 1'b0;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (r_state == ST_ADD);
    assign done      = (r_state == ST_DONE);
    assign sum       = r_sum;
    assign carry_out = r_cout;
    assign error     = r_err;

endmodule
`default_nettype wire
